// File: rtl/mul_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit_if
//  Purpose  : Request/result bundle for the iterative multiply/divide unit.
//             Holds the operation request, the busy/done status and the
//             HI/LO result registers.
//  Revision : 1.0  initial release
// ============================================================================
interface mul_div_unit_if;
    logic        start;
    logic [5:0]  ALUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    // Requester side: issues operations and reads status/results
    modport master (
        output start, ALUOp, A, B,
        input  busy, done, HI, LO
    );

    // Unit side: accepts operations and owns HI/LO
    modport slave (
        input  start, ALUOp, A, B,
        output busy, done, HI, LO
    );
endinterface
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative 32x32 multiply (shift-add) and restoring divide with
//             HI/LO result registers. One bit per cycle, fixed 34-cycle
//             occupancy from accept to return-to-idle. MTHI/MTLO write HI/LO
//             directly from A without leaving IDLE.
//  Revision : 1.0  initial release
// ============================================================================
module mul_div_unit (
    input  wire logic     clk,
    input  wire logic     rst,
    mul_div_unit_if.slave bus
);

    // Operation codes (R-type funct encoding)
    localparam logic [5:0] c_OP_MTHI  = 6'b010001;
    localparam logic [5:0] c_OP_MTLO  = 6'b010011;
    localparam logic [5:0] c_OP_MULT  = 6'b011000;
    localparam logic [5:0] c_OP_MULTU = 6'b011001;
    localparam logic [5:0] c_OP_DIV   = 6'b011010;
    localparam logic [5:0] c_OP_DIVU  = 6'b011011;

    // Controller states
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    // Iteration count at which the result is finalised
    localparam logic [5:0] c_LAST_CNT = 6'd32;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [5:0]  r_cnt;
    // Multiply: {partial product high, multiplier shifting out low}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [63:0] r_acc;
    // Multiplicand (multiply) or divisor (divide), magnitude form
    logic [31:0] r_opnd;
    logic        r_is_div;
    logic        r_neg_main;   // negate product / quotient
    logic        r_neg_rem;    // negate remainder
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]  w_next_state;
    logic        w_busy;
    logic        w_done;
    logic        w_is_muldiv;
    logic        w_accept;
    logic        w_last;
    logic        w_op_is_div;
    logic        w_op_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_shift;
    logic [33:0] w_div_diff;
    logic        w_div_ok;
    logic [63:0] w_acc_next;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Decode: the four mul/div opcodes share the 0110xx prefix;
    // bit 1 selects divide, bit 0 selects unsigned.
    assign w_is_muldiv = (bus.ALUOp == c_OP_MULT) || (bus.ALUOp == c_OP_MULTU) ||
                         (bus.ALUOp == c_OP_DIV)  || (bus.ALUOp == c_OP_DIVU);
    assign w_op_is_div = bus.ALUOp[1];
    assign w_op_signed = ~bus.ALUOp[0];
    assign w_accept    = (r_state == c_ST_IDLE) && bus.start && w_is_muldiv;
    assign w_last      = (r_cnt == c_LAST_CNT);

    assign w_a_neg = w_op_signed & bus.A[31];
    assign w_b_neg = w_op_signed & bus.B[31];
    assign w_a_mag = w_a_neg ? (32'd0 - bus.A) : bus.A;
    assign w_b_mag = w_b_neg ? (32'd0 - bus.B) : bus.B;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift the whole accumulator right by one.
    assign w_mul_sum = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);

    // Restoring step: shift the next dividend bit into the partial remainder
    // and try a 33-bit subtract of the divisor. Bit 32 of the difference is
    // always zero when the subtract succeeds; folding it in keeps the
    // compare exact without leaving the bit dangling.
    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_opnd};
    assign w_div_ok    = ~(w_div_diff[33] | w_div_diff[32]);

    // One iteration of whichever algorithm is in flight
    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            w_acc_next = {(w_div_ok ? w_div_diff[31:0] : w_div_shift[31:0]),
                          r_acc[30:0], w_div_ok};
        end else begin
            w_acc_next = {w_mul_sum, r_acc[31:1]};
        end
    end

    // Sign fix-up applied when the result is written to HI/LO
    assign w_prod_fix = r_neg_main ? (64'd0 - r_acc) : r_acc;
    assign w_quo_fix  = r_neg_main ? (32'd0 - r_acc[31:0])  : r_acc[31:0];
    assign w_rem_fix  = r_neg_rem  ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: accept in IDLE, finalise after 32 iterations, one DONE cycle
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: if (w_accept) w_next_state = c_ST_RUN;
            c_ST_RUN:  if (w_last)   w_next_state = c_ST_DONE;
            c_ST_DONE: w_next_state = c_ST_IDLE;
            default:   w_next_state = c_ST_IDLE;
        endcase
    end

    // Status outputs decoded from state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            c_ST_RUN:  w_busy = 1'b1;
            c_ST_DONE: begin
                w_busy = 1'b1;
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Operand latch on accept, then one iteration per RUN cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 6'd0;
            r_acc      <= 64'd0;
            r_opnd     <= 32'd0;
            r_is_div   <= 1'b0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= 6'd0;
            r_is_div <= w_op_is_div;
            if (w_op_is_div) begin
                r_acc  <= {32'd0, w_a_mag};
                r_opnd <= w_b_mag;
                // Divide-by-zero must return an all-ones quotient untouched,
                // so the quotient sign flip is suppressed when B is zero.
                r_neg_main <= (w_a_neg ^ w_b_neg) && (bus.B != 32'd0);
                r_neg_rem  <= w_a_neg;
            end else begin
                r_acc      <= {32'd0, w_b_mag};
                r_opnd     <= w_a_mag;
                r_neg_main <= w_a_neg ^ w_b_neg;
                r_neg_rem  <= 1'b0;
            end
        end else if ((r_state == c_ST_RUN) && !w_last) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
        end
    end

    // HI/LO: written only on DONE entry or by MTHI/MTLO in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if ((r_state == c_ST_RUN) && w_last) begin
            if (r_is_div) begin
                r_hi <= w_rem_fix;
                r_lo <= w_quo_fix;
            end else begin
                r_hi <= w_prod_fix[63:32];
                r_lo <= w_prod_fix[31:0];
            end
        end else if ((r_state == c_ST_IDLE) && bus.start) begin
            if (bus.ALUOp == c_OP_MTHI) r_hi <= bus.A;
            if (bus.ALUOp == c_OP_MTLO) r_lo <= bus.A;
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.HI   = r_hi;
    assign bus.LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Directed self-checking bench for mul_div_unit: signed/unsigned
//             multiply and divide, overflow and divide-by-zero corners,
//             MTHI/MTLO, ignored starts and reset abort.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

    localparam logic [5:0] c_MFHI  = 6'b010000;
    localparam logic [5:0] c_MTHI  = 6'b010001;
    localparam logic [5:0] c_MTLO  = 6'b010011;
    localparam logic [5:0] c_MULT  = 6'b011000;
    localparam logic [5:0] c_MULTU = 6'b011001;
    localparam logic [5:0] c_DIV   = 6'b011010;
    localparam logic [5:0] c_DIVU  = 6'b011011;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mul_div_unit_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sampling and driving happen 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div and check latency, result and post-done behaviour.
    // dist_cyc > 0 injects a competing DIVU start plus operand changes at
    // that RUN cycle.
    task automatic run_op(input string tag, input logic [5:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int dist_cyc);
        int          cyc;
        int          busy_low;
        int          hold_bad;
        int          extra_done;
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0       = bus.HI;
        lo0       = bus.LO;
        bus.start = 1'b1;
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
        step();
        bus.start = 1'b0;
        cyc       = 1;
        busy_low  = 0;
        hold_bad  = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            if (bus.busy !== 1'b1) busy_low++;
            if (bus.HI !== hi0 || bus.LO !== lo0) hold_bad++;
            bus.start = (cyc == dist_cyc);
            if (cyc == dist_cyc) begin
                bus.ALUOp = c_DIVU;
                bus.A     = 32'h0000_0064;
                bus.B     = 32'h0000_0007;
            end
            step();
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, " done_cycle"}, 32'(cyc), 32'd34);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd1);
        check({tag, " HI"}, bus.HI, exp_hi);
        check({tag, " LO"}, bus.LO, exp_lo);
        check({tag, " busy_gaps"}, 32'(busy_low), 32'd0);
        check({tag, " hold_in_run"}, 32'(hold_bad), 32'd0);
        step();
        check({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " done_after"}, {31'd0, bus.done}, 32'd0);
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra_done++;
            step();
        end
        check({tag, " no_second_done"}, 32'(extra_done), 32'd0);
        check({tag, " HI_held"}, bus.HI, exp_hi);
        check({tag, " LO_held"}, bus.LO, exp_lo);
    endtask

    initial begin
        int          cyc;
        int          stray;
        logic [31:0] hi_keep;
        logic [31:0] lo_keep;

        // Reset state
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.ALUOp = 6'd0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        step();
        step();
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst HI", bus.HI, 32'd0);
        check("rst LO", bus.LO, 32'd0);
        rst = 1'b0;
        step();

        // Multiply
        run_op("mult_neg", c_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("multu", c_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 0);
        run_op("mult_max", c_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 0);

        // Divide
        run_op("div_neg", c_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_op("div_pos_negb", c_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_op("divu", c_DIVU, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 0);
        run_op("divu_by0", c_DIVU, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 0);
        run_op("div_by0_neg", c_DIV, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 0);

        // MTHI / MTLO stay in IDLE
        bus.start = 1'b1;
        bus.ALUOp = c_MTHI;
        bus.A     = 32'h1234_5678;
        step();
        bus.start = 1'b0;
        check("mthi HI", bus.HI, 32'h1234_5678);
        check("mthi LO_kept", bus.LO, 32'hFFFF_FFFF);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        check("mthi done", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b1;
        bus.ALUOp = c_MTLO;
        bus.A     = 32'hCAFE_F00D;
        step();
        bus.start = 1'b0;
        check("mtlo LO", bus.LO, 32'hCAFE_F00D);
        check("mtlo HI_kept", bus.HI, 32'h1234_5678);
        check("mtlo busy", {31'd0, bus.busy}, 32'd0);

        // MFHI and an unrecognised op change nothing
        bus.start = 1'b1;
        bus.ALUOp = c_MFHI;
        bus.A     = 32'hDEAD_BEEF;
        step();
        check("mfhi busy", {31'd0, bus.busy}, 32'd0);
        check("mfhi HI", bus.HI, 32'h1234_5678);
        bus.ALUOp = 6'b100000;
        step();
        bus.start = 1'b0;
        check("badop busy", {31'd0, bus.busy}, 32'd0);
        check("badop LO", bus.LO, 32'hCAFE_F00D);

        // MULT with a competing DIVU start at RUN cycle 5
        run_op("mult_ignore", c_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);

        // Reset overrides start on the same edge
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.ALUOp = c_MULT;
        bus.A     = 32'h0000_0005;
        bus.B     = 32'h0000_0007;
        step();
        check("rst_vs_start busy", {31'd0, bus.busy}, 32'd0);
        check("rst_vs_start HI", bus.HI, 32'd0);
        rst = 1'b0;
        bus.start = 1'b0;
        step();

        // Put known non-zero values in HI/LO, then abort a MULT at RUN cycle 10
        bus.start = 1'b1;
        bus.ALUOp = c_MTHI;
        bus.A     = 32'h5555_AAAA;
        step();
        bus.ALUOp = c_MTLO;
        bus.A     = 32'hAAAA_5555;
        step();
        hi_keep = bus.HI;
        lo_keep = bus.LO;
        check("pre_abort HI", hi_keep, 32'h5555_AAAA);
        check("pre_abort LO", lo_keep, 32'hAAAA_5555);
        bus.ALUOp = c_MULT;
        bus.A     = 32'h0000_0005;
        bus.B     = 32'h0000_0007;
        step();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            step();
            cyc++;
        end
        check("abort busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort busy", {31'd0, bus.busy}, 32'd0);
        check("abort done", {31'd0, bus.done}, 32'd0);
        check("abort HI", bus.HI, 32'd0);
        check("abort LO", bus.LO, 32'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 ||
                bus.HI !== 32'd0 || bus.LO !== 32'd0) stray++;
            step();
        end
        check("abort no_late_done", 32'(stray), 32'd0);

        // Unit still works after an abort
        run_op("after_abort", c_MULTU, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0023, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
